// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter.
// Frames a DATA_WIDTH word as start bit, data LSB-first, optional even
// parity and stop bit. Each bit is held for CLKS_PER_BIT clocks. All outputs
// come straight from flops, so no input reaches tx_serial combinationally.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  parity, parity_d;
  logic                  serial_d, ready_d, busy_d, done_d;
  logic                  bit_end;

  // Last clock of the current bit period.
  assign bit_end = (cnt == CNT_LAST);

  // Next-state, datapath and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shreg_d  = shreg;
    parity_d = parity;
    done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d  = tx_data;
          parity_d = ^tx_data;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg >> 1;
          if (idx == IDX_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) state_d = PARITY;
            else                state_d = STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered below.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_d[0];
      PARITY:  serial_d = parity_d;
      default: serial_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      parity    <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shreg     <= shreg_d;
      parity    <= parity_d;
      tx_serial <= serial_d;
      tx_ready  <= ready_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx. A queue model expands
// each accepted word into its per-cycle line levels; a negedge process
// compares two DUT instances (default and alternate parameters) against it.
module tb_serial_tx;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int P  = 1;
  localparam int AW = 4;
  localparam int AC = 1;
  localparam int AP = 0;

  logic          clock = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic          tx_ready, tx_serial, tx_busy, tx_done;
  logic          a_valid;
  logic [AW-1:0] a_data;
  logic          a_ready, a_serial, a_busy, a_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(P)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  serial_tx #(.DATA_WIDTH(AW), .CLKS_PER_BIT(AC), .PARITY_EN(AP)) dut_alt (
    .clock(clock), .reset(reset), .tx_valid(a_valid), .tx_data(a_data),
    .tx_ready(a_ready), .tx_serial(a_serial), .tx_busy(a_busy), .tx_done(a_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on accept, the whole frame is queued as one line level per cycle.
  bit mq[$];
  bit aq[$];
  bit m_done = 1'b0;
  bit a_done_exp = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() == 0) begin
      m_done = 1'b0;
      if (tx_valid) begin
        for (int c = 0; c < C; c++) mq.push_back(1'b0);
        for (int i = 0; i < W; i++)
          for (int c = 0; c < C; c++) mq.push_back(tx_data[i]);
        if (P != 0)
          for (int c = 0; c < C; c++) mq.push_back(^tx_data);
        for (int c = 0; c < C; c++) mq.push_back(1'b1);
      end
    end else begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      aq.delete();
      a_done_exp = 1'b0;
    end else if (aq.size() == 0) begin
      a_done_exp = 1'b0;
      if (a_valid) begin
        for (int c = 0; c < AC; c++) aq.push_back(1'b0);
        for (int i = 0; i < AW; i++)
          for (int c = 0; c < AC; c++) aq.push_back(a_data[i]);
        if (AP != 0)
          for (int c = 0; c < AC; c++) aq.push_back(^a_data);
        for (int c = 0; c < AC; c++) aq.push_back(1'b1);
      end
    end else begin
      void'(aq.pop_front());
      a_done_exp = (aq.size() == 0);
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clock) begin
    check("serial", tx_serial, (mq.size() != 0) ? mq[0] : 1'b1);
    check("busy",   tx_busy,   mq.size() != 0);
    check("ready",  tx_ready,  mq.size() == 0);
    check("done",   tx_done,   m_done);
    check("alt_serial", a_serial, (aq.size() != 0) ? aq[0] : 1'b1);
    check("alt_busy",   a_busy,   aq.size() != 0);
    check("alt_ready",  a_ready,  aq.size() == 0);
    check("alt_done",   a_done,   a_done_exp);
  end

  // Capture buffers indexed by cycles after the accept edge (1 = first start cycle).
  logic ser [0:99];
  logic bsy [0:99];
  logic dn  [0:99];

  // Samples n cycles; optionally drives a new word at cycle inj and drops valid at drop.
  task automatic capture(input int n, input int inj, input logic [W-1:0] inj_data, input int drop);
    for (int k = 1; k <= n; k++) begin
      ser[k] = tx_serial;
      bsy[k] = tx_busy;
      dn[k]  = tx_done;
      if (k == inj) begin
        tx_data  = inj_data;
        tx_valid = 1'b1;
      end
      if (k == drop) tx_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  // Checks the mid-bit level of each of the 11 bits of a default frame.
  task automatic check_frame(input string name, input int base, input logic [10:0] lit);
    for (int b = 0; b < 11; b++)
      check(name, ser[base + 4*b + 2], lit[b]);
  endtask

  function automatic int count_ones(input int from, input int to, input bit which);
    int s = 0;
    for (int k = from; k <= to; k++)
      if (which ? dn[k] : bsy[k]) s++;
    return s;
  endfunction

  initial begin
    logic [10:0] lit;
    logic [7:0]  alt_lit;
    int          cnt;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; a_valid = 1'b0; a_data = '0;

    // Reset, then idle for 10 cycles.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("idle_serial", tx_serial, 1'b1);
      check("idle_ready",  tx_ready,  1'b1);
      check("idle_busy",   tx_busy,   1'b0);
      check("idle_done",   tx_done,   1'b0);
      @(negedge clock);
    end

    // 0xA5 with a single-cycle valid.
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    capture(50, 0, '0, 0);
    lit = {1'b1, 1'b0, 8'hA5, 1'b0};
    check_frame("a5_bit", 0, lit);
    check("a5_busy_len",  count_ones(1, 50, 1'b0), 44);
    check("a5_done_cnt",  count_ones(1, 50, 1'b1), 1);
    check("a5_done_at45", dn[45], 1'b1);
    repeat (5) @(negedge clock);

    // 0x07, then a request with 0xFF while busy is ignored.
    tx_data = 8'h07; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    capture(60, 13, 8'hFF, 14);
    lit = {1'b1, 1'b1, 8'h07, 1'b0};
    check_frame("x07_bit", 0, lit);
    check("x07_done_cnt", count_ones(1, 60, 1'b1), 1);
    check("x07_done_at45", dn[45], 1'b1);
    check("x07_no_refire", count_ones(46, 60, 1'b0), 0);
    repeat (5) @(negedge clock);

    // Back-to-back with valid held high.
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clock);
    capture(90, 1, 8'hC3, 47);
    lit = {1'b1, 1'b0, 8'h3C, 1'b0};
    check_frame("b2b_first", 0, lit);
    lit = {1'b1, 1'b0, 8'hC3, 1'b0};
    check_frame("b2b_second", 45, lit);
    check("b2b_stop",     ser[44], 1'b1);
    check("b2b_gap_ser",  ser[45], 1'b1);
    check("b2b_gap_busy", bsy[45], 1'b0);
    check("b2b_gap_done", dn[45],  1'b1);
    check("b2b_start",    ser[46], 1'b0);
    check("b2b_start_bsy", bsy[46], 1'b1);
    repeat (5) @(negedge clock);

    // Reset during data bit 3 of 0xFF.
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (17) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_ready",  tx_ready,  1'b1);
    check("rst_busy",   tx_busy,   1'b0);
    check("rst_done",   tx_done,   1'b0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_done) cnt++;
      @(negedge clock);
    end
    check("rst_no_done", cnt, 0);
    tx_data = 8'h01; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    capture(50, 0, '0, 0);
    lit = {1'b1, 1'b1, 8'h01, 1'b0};
    check_frame("x01_bit", 0, lit);
    check("x01_done_cnt", count_ones(1, 50, 1'b1), 1);

    // Alternate instance: 0x9, 1 clock per bit, no parity.
    a_data = 4'h9; a_valid = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    alt_lit = 8'b0011_0010;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 6) check("alt_bit", a_serial, alt_lit[k-1]);
      else        check("alt_idle", a_serial, 1'b1);
      check("alt_done_at", a_done, k == 7);
      @(negedge clock);
    end

    // Randomized traffic on both instances, with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = W'($urandom);
      a_valid  = ($urandom_range(0, 2) == 0);
      a_data   = AW'($urandom);
      reset    = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    reset = 1'b0; tx_valid = 1'b0; a_valid = 1'b0;
    repeat (60) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
